// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 constants shared by the key-schedule engine
package aes_pkg;

  localparam int NR = 10;
  localparam int NK = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_SERVE  = 2'd2
  } state_e;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = 255 - int'(b);
    return SBOX[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/sub_word.sv
// rtl/sub_word.sv - combinational SubWord: four parallel S-box lookups
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  always_comb begin
    word_out = '0;
    for (int i = 0; i < 4; i++) begin
      word_out[i*8 +: 8] = sbox(word_in[i*8 +: 8]);
    end
  end

endmodule

// File: rtl/round_key_gen.sv
// rtl/round_key_gen.sv - iterative AES-128 key expansion with a buffered
// schedule served forward or reverse, one key per request
module round_key_gen
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] cipher_key,
  input  logic         dir,
  input  logic         key_req,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         last,
  output logic         busy,
  output logic         ready
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   ptr_q, ptr_d;
  logic         rev_q, rev_d;
  logic [127:0] rk_q [0:NR];
  logic [127:0] rk_d [0:NR];

  logic [3:0]   prev_idx;
  logic [127:0] prev_key;
  logic [31:0]  w3_rot;
  logic [31:0]  w3_sub;
  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic         serving;
  logic         last_w;

  // rnd_q never leaves 1..NR, so prev_idx always addresses a written key.
  assign prev_idx = rnd_q - 4'd1;
  assign prev_key = rk_q[prev_idx];
  assign w3_rot   = {prev_key[103:96], prev_key[127:104]};

  sub_word u_sub_word (
    .word_in  (w3_rot),
    .word_out (w3_sub)
  );

  assign t_word = w3_sub ^ {24'h0, RCON[rnd_q]};
  assign n0     = prev_key[31:0]   ^ t_word;
  assign n1     = prev_key[63:32]  ^ n0;
  assign n2     = prev_key[95:64]  ^ n1;
  assign n3     = prev_key[127:96] ^ n2;

  assign serving = (state_q == ST_SERVE);
  assign last_w  = rev_q ? (ptr_q == 4'd0) : (ptr_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    ptr_d   = ptr_q;
    rev_d   = rev_q;
    rk_d    = rk_q;
    if (load) begin
      rk_d[0] = cipher_key;
      rnd_d   = 4'd1;
      state_d = ST_EXPAND;
    end else begin
      case (state_q)
        ST_EXPAND: begin
          rk_d[rnd_q] = {n3, n2, n1, n0};
          if (rnd_q == LAST_IDX) begin
            state_d = ST_SERVE;
            ptr_d   = dir ? LAST_IDX : 4'd0;
            rev_d   = dir;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
        ST_SERVE: begin
          // Direction is only resampled at a wrap so a block never mixes orders.
          if (key_req) begin
            if (last_w) begin
              ptr_d = dir ? LAST_IDX : 4'd0;
              rev_d = dir;
            end else begin
              ptr_d = rev_q ? (ptr_q - 4'd1) : (ptr_q + 4'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= 4'd1;
      ptr_q   <= 4'd0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      ptr_q   <= ptr_d;
      rev_q   <= rev_d;
    end
    rk_q <= rk_d;
  end

  assign round_key = serving ? rk_q[ptr_q] : 128'h0;
  assign round_idx = serving ? ptr_q : 4'd0;
  assign key_valid = serving;
  assign ready     = serving;
  assign last      = serving & last_w;
  assign busy      = (state_q == ST_EXPAND);

endmodule

// File: tb/tb_round_key_gen.sv
// tb/tb_round_key_gen.sv - randomized bench for round_key_gen against a
// FIPS-197 style key-expansion model built from GF(2^8) arithmetic
module tb_round_key_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [127:0] cipher_key = '0;
  logic         dir = 1'b0;
  logic         key_req = 1'b0;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         last;
  logic         busy;
  logic         ready;

  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  round_key_gen #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .cipher_key (cipher_key),
    .dir        (dir),
    .key_req    (key_req),
    .round_key  (round_key),
    .round_idx  (round_idx),
    .key_valid  (key_valid),
    .last       (last),
    .busy       (busy),
    .ready      (ready)
  );

  // Reference S-box derived from the field inverse plus affine map.
  logic [7:0]   sbox_t [0:255];
  logic [127:0] model_rk [0:10];
  int           m_st = 0;
  int           m_cnt = 0;
  int           m_ptr = 0;
  bit           m_fwd = 1'b1;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] x = 8'(v);
      logic [7:0] inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gf_mul(inv, x);
      if (v == 0) inv = 8'h00;
      sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [7:0] kb [0:175];
    logic [7:0] tmp [0:3];
    logic [7:0] s0;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 16; i++) kb[i] = key[i*8 +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = kb[4*(i-1) + j];
      if (i % 4 == 0) begin
        s0 = tmp[0];
        tmp[0] = sbox_t[tmp[1]] ^ rc;
        tmp[1] = sbox_t[tmp[2]];
        tmp[2] = sbox_t[tmp[3]];
        tmp[3] = sbox_t[s0];
        rc = gf_mul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) kb[4*i + j] = kb[4*(i-4) + j] ^ tmp[j];
    end
    for (int r = 0; r < 11; r++)
      for (int i = 0; i < 16; i++) model_rk[r][i*8 +: 8] = kb[16*r + i];
  endtask

  // Literals below are written byte 0 first; this flips them into port packing.
  function automatic logic [127:0] lit(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = x[(15-i)*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_tick();
    bit m_last = m_fwd ? (m_ptr == 10) : (m_ptr == 0);
    if (rst) begin
      m_st = 0;
    end else if (load) begin
      model_expand(cipher_key);
      m_st = 1;
      m_cnt = 10;
    end else if (m_st == 1) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_st = 2;
        m_fwd = !dir;
        m_ptr = dir ? 10 : 0;
      end
    end else if (m_st == 2 && key_req) begin
      if (m_last) begin
        m_fwd = !dir;
        m_ptr = dir ? 10 : 0;
      end else begin
        m_ptr = m_fwd ? m_ptr + 1 : m_ptr - 1;
      end
    end
  endtask

  task automatic compare_outputs();
    bit srv = (m_st == 2);
    chk("key_valid", 128'(key_valid), 128'(srv));
    chk("ready", 128'(ready), 128'(srv));
    chk("busy", 128'(busy), 128'(m_st == 1));
    chk("last", 128'(last), 128'(srv && (m_fwd ? (m_ptr == 10) : (m_ptr == 0))));
    chk("round_idx", 128'(round_idx), srv ? 128'(m_ptr) : 128'h0);
    chk("round_key", round_key, srv ? model_rk[m_ptr] : 128'h0);
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    compare_outputs();
  endtask

  task automatic req(input int n);
    key_req = 1'b1;
    repeat (n) step();
    key_req = 1'b0;
  endtask

  logic [127:0] fips_key, fips_rk1, fips_rk10, zero_rk10;

  initial begin
    fips_key  = lit(128'h2b7e151628aed2a6abf7158809cf4f3c);
    fips_rk1  = lit(128'ha0fafe1788542cb123a339392a6c7605);
    fips_rk10 = lit(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    zero_rk10 = lit(128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    build_sbox();
    for (int r = 0; r < 11; r++) model_rk[r] = '0;

    repeat (3) step();
    rst = 1'b0;
    step();

    // Forward service of the FIPS-197 key.
    cipher_key = fips_key;
    dir = 1'b0;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("model_rk1", model_rk[1], fips_rk1);
    chk("model_rk10", model_rk[10], fips_rk10);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 9) chk("ready_before_10", 128'(ready), 128'h0);
      if (i == 10) chk("ready_at_10", 128'(ready), 128'h1);
    end
    chk("fwd_rk0", round_key, fips_key);
    req(1);
    chk("fwd_rk1", round_key, fips_rk1);
    req(9);
    chk("fwd_rk10", round_key, fips_rk10);
    chk("fwd_idx10", 128'(round_idx), 128'd10);
    chk("fwd_last", 128'(last), 128'h1);

    // Wrap with no gap, then a mid-sequence dir change that waits for the wrap.
    req(1);
    chk("wrap_idx0", 128'(round_idx), 128'd0);
    req(5);
    dir = 1'b1;
    req(5);
    chk("dir_deferred_idx", 128'(round_idx), 128'd10);
    req(1);
    chk("rev_start_idx", 128'(round_idx), 128'd10);
    chk("rev_start_key", round_key, fips_rk10);
    req(10);
    chk("rev_end_idx", 128'(round_idx), 128'd0);
    chk("rev_end_last", 128'(last), 128'h1);
    chk("rev_end_key", round_key, fips_key);

    // All-zero key loaded mid-SERVE together with a request.
    cipher_key = '0;
    load = 1'b1;
    key_req = 1'b1;
    step();
    load = 1'b0;
    key_req = 1'b0;
    chk("reload_valid", 128'(key_valid), 128'h0);
    chk("reload_last", 128'(last), 128'h0);
    chk("model_zero_rk10", model_rk[10], zero_rk10);
    repeat (10) step();
    chk("zero_rk10", round_key, zero_rk10);
    chk("zero_idx", 128'(round_idx), 128'd10);

    // Reset in the middle of expansion, then requests that must be ignored.
    cipher_key = fips_key;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_key", round_key, 128'h0);
    req(15);
    chk("idle_req_valid", 128'(key_valid), 128'h0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      load = ($urandom_range(0, 39) == 0);
      if (load) cipher_key = {$urandom, $urandom, $urandom, $urandom};
      key_req = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    load = 1'b0;
    key_req = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/round_key_gen.md
# round_key_gen

Iterative AES-128 key-schedule engine. It expands one 128-bit cipher key into the 11 round keys, buffers them, and serves them one per request in forward order (encryption) or reverse order (decryption) to the addRoundKey stages. It sits beside the round datapath as the producer side of their `key` input. It lets the same pipeline run the inverse cipher without recomputing the schedule for every block.

## Interface
Parameters:
- `NR`, 10, number of rounds; fixed for AES-128, other values unsupported.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  single-cycle pulse; start expansion of `cipher_key`.
- `cipher_key`  in  128  byte i at `[i*8 +: 8]`; bytes 0–3 form column/word 0.
- `dir`  in  1  0 = serve rk0→rk10, 1 = serve rk10→rk0.
- `key_req`  in  1  consume current key, advance pointer.
- `round_key`  out  128  current round key, same byte packing.
- `round_idx`  out  4  index (0–10) of `round_key`.
- `key_valid`  out  1  `round_key` is valid.
- `last`  out  1  current key is the final one of the sequence.
- `busy`  out  1  expansion in progress.
- `ready`  out  1  schedule complete, serving.

## Operation
- FSM states are IDLE, EXPAND, SERVE. Reset enters IDLE.
- IDLE: all outputs 0. `key_req` is ignored.
- On `load` in any state:
  - `rk[0] ← cipher_key`, round counter ← 1, state → EXPAND.
  - In SERVE, this discards the old schedule.
- EXPAND computes one round key per cycle, `rk[r]` from `rk[r-1]`. Words w0..w3 are `[31:0]`..`[127:96]`:
  - `t = SubWord(RotWord(w3)) ^ Rcon[r]`.
  - RotWord maps bytes (b0,b1,b2,b3) → (b1,b2,b3,b0).
  - Rcon is XORed into byte 0 only.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- After `rk[10]` is written, state → SERVE. `dir` is sampled at this point; ptr ← 0 if `dir`=0, else 10.
- SERVE:
  - `key_valid`=1, `ready`=1.
  - `round_key`=`rk[ptr]`, `round_idx`=ptr.
  - `last`=1 when ptr is 10 (forward) or 0 (reverse).
- `key_req` in SERVE:
  - If not `last`: ptr steps by ±1.
  - If `last`: wrap. `dir` is resampled and ptr reloads to 0 or 10, so the next block reuses the schedule.
- `dir` changes mid-sequence take effect only at the next wrap.
- `key_req` outside SERVE is ignored and never queued.
- `load` and `key_req` in the same cycle: `load` wins and the request is dropped.
- `rst` mid-EXPAND or mid-SERVE: state → IDLE on that edge and all outputs → 0. Buffer contents are don't-care.

## Timing
- All outputs are registered or decoded from registers only. There are no input-to-output combinational paths.
- `load` sampled on edge T:
  - `busy`=1 after edges T … T+9.
  - `rk[r]` is written on edge T+r.
  - After edge T+10: `busy`=0, `ready`=1, `key_valid`=1.
  - Expansion latency is 10 cycles.
- `key_req` sampled on edge E: the new `round_key`/`round_idx` is visible after E. Throughput is one key per cycle with back-to-back requests.
- `load` in SERVE on edge E: `ready`, `key_valid` and `last` are 0 after E.

## Structure
- The shared package `aes_pkg` holds:
  - the 256-entry S-box constant;
  - the `RCON[1:10]` constant array;
  - the `NR`/`NK` constants;
  - the FSM state enum.
- Sub-module `sub_word`: combinational 32-bit SubWord (4 S-box lookups). Instantiated once for the RotWord'd w3.
- Key buffer: 11×128 register array. Round counter and ptr: 4 bits each.

## Test plan
- FIPS-197 A.1 key, bytes 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c (byte 0 first):
  - `load`, then `dir`=0: `ready` rises exactly 10 cycles later.
  - Requests yield rk1 = a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05.
  - rk10 = d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6, with `last`=1 and `round_idx`=10.
- Same key with `dir`=1:
  - The first served key is rk10 (above), indices count 10→0.
  - `last` is asserted with rk0 = the cipher key.
- Wrap: 11 back-to-back `key_req` in forward mode, then one more.
  - `round_idx` returns to 0 with no gap.
  - Raise `dir` before the wrap: the next sequence starts at 10.
- `load` of all-zero key mid-SERVE:
  - `key_valid` drops next cycle.
  - After 10 cycles rk10 = b4 ef 5b cb 3e 92 e2 11 23 e9 51 cf 6f 8f 18 8e.
- `rst` asserted at cycle 5 of EXPAND:
  - All outputs 0 next cycle.
  - `key_req` is ignored until a new `load`.
- `load` and `key_req` asserted together in SERVE: the restart occurs and ptr does not advance.
